// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer that drives a 1-bit alu1 slice LSB first, threading the
// slice carry between bits and assembling a WIDTH-bit result.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// RUN   | one operand bit per clock pushed through the slice
// DONE  | result held on the response port until rsp_ready
module alu_serial_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_select,
  input  logic             req_carry_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_carry_in,
  output logic [2:0]       alu_select,
  input  logic             alu_out,
  input  logic             alu_carry_out
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [2:0]       sel_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB so bit 0 lands at res_sh[0] after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      sel_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sh    <= req_a;
            b_sh    <= req_b;
            sel_r   <= req_select;
            carry_r <= req_carry_in;
            res_sh  <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          res_sh  <= {alu_out, res_sh[WIDTH-1:1]};
          carry_r <= alu_carry_out;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          idx     <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready     = rst_n && (state == IDLE);
    rsp_valid     = (state == DONE);
    rsp_result    = (state == DONE) ? res_sh : '0;
    rsp_carry_out = (state == DONE) ? carry_r : 1'b0;
    alu_a         = (state == RUN) ? a_sh[0] : 1'b0;
    alu_b         = (state == RUN) ? b_sh[0] : 1'b0;
    alu_carry_in  = (state == RUN) ? carry_r : 1'b0;
    alu_select    = sel_r;
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer at WIDTH=4 and WIDTH=8, each with a
// behavioural alu1 slice: select[2]=1 full adder, else NOT/OR/XOR/AND with carry 0.
module tb_alu_serial_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [1:0] slice(logic a, logic b, logic cin, logic [2:0] sel);
    if (sel[2]) return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    case (sel[1:0])
      2'b00:   return {1'b0, ~a};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a ^ b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  // ---------------- WIDTH=4 instance ----------------
  logic       req_valid = 1'b0, rsp_ready = 1'b1, req_carry_in = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [2:0] req_select = '0;
  logic       req_ready, rsp_valid, rsp_carry_out;
  logic [3:0] rsp_result;
  logic       alu_a, alu_b, alu_carry_in, alu_out, alu_carry_out;
  logic [2:0] alu_select;

  assign {alu_carry_out, alu_out} = slice(alu_a, alu_b, alu_carry_in, alu_select);

  alu_serial_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_select(req_select), .req_carry_in(req_carry_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry_out(rsp_carry_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_select(alu_select),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic       req_valid8 = 1'b0, req_carry_in8 = 1'b0;
  logic [7:0] req_a8 = '0, req_b8 = '0;
  logic [2:0] req_select8 = '0;
  logic       req_ready8, rsp_valid8, rsp_carry_out8;
  logic [7:0] rsp_result8;
  logic       alu_a8, alu_b8, alu_carry_in8, alu_out8, alu_carry_out8;
  logic [2:0] alu_select8;

  assign {alu_carry_out8, alu_out8} = slice(alu_a8, alu_b8, alu_carry_in8, alu_select8);

  alu_serial_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_a(req_a8), .req_b(req_b8),
    .req_select(req_select8), .req_carry_in(req_carry_in8),
    .rsp_valid(rsp_valid8), .rsp_ready(1'b1), .rsp_result(rsp_result8),
    .rsp_carry_out(rsp_carry_out8),
    .alu_a(alu_a8), .alu_b(alu_b8), .alu_carry_in(alu_carry_in8), .alu_select(alu_select8),
    .alu_out(alu_out8), .alu_carry_out(alu_carry_out8)
  );

  typedef struct {
    logic [7:0] res;
    logic       co;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];

  // ---------------- monitors ----------------
  bit         in_rsp = 0;
  logic [3:0] held_res;
  logic       held_co;
  int         last_hs = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!in_rsp) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_result), 32'hdead);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(e.res[3:0]));
          chk("rsp_carry", 32'(rsp_carry_out), 32'(e.co));
          chk("rsp_latency", 32'(cyc - e.acc), 32'd4);
        end
        held_res = rsp_result;
        held_co  = rsp_carry_out;
      end else begin
        chk("hold_result", 32'(rsp_result), 32'(held_res));
        chk("hold_carry", 32'(rsp_carry_out), 32'(held_co));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_ready) begin
        in_rsp  = 0;
        last_hs = cyc + 1;
      end else begin
        in_rsp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid8) begin
      if (q8.size() == 0) begin
        chk("unexpected_rsp8", 32'(rsp_result8), 32'hdead);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("rsp8_result", 32'(rsp_result8), 32'(e.res));
        chk("rsp8_carry", 32'(rsp_carry_out8), 32'(e.co));
        chk("rsp8_latency", 32'(cyc - e.acc), 32'd8);
      end
    end
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic cin, input logic [3:0] eres, input logic eco,
                       input bit push, output int acc);
    int guard = 0;
    req_a = a; req_b = b; req_select = sel; req_carry_in = cin; req_valid = 1'b1;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    acc = cyc + 1;
    if (push) q.push_back('{res: {4'h0, eres}, co: eco, acc: acc});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] eres, input logic eco);
    int guard = 0;
    req_a8 = a; req_b8 = b; req_select8 = 3'b100; req_carry_in8 = cin; req_valid8 = 1'b1;
    while (!req_ready8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready8) chk("req8_accept_timeout", 32'(req_ready8), 32'd1);
    q8.push_back('{res: eres, co: eco, acc: cyc + 1});
    @(negedge clk);
    req_valid8 = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || q8.size() != 0 || !req_ready || !req_ready8) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 200), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc1, acc2, t_hs;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry_out), 32'd0);
    chk("rst_alu_bus", 32'({alu_a, alu_b, alu_carry_in, alu_select}), 32'd0);

    // logic ops
    issue(4'b1100, 4'b1010, 3'b011, 1'b0, 4'b1000, 1'b0, 1, acc1);
    issue(4'b0101, 4'b0000, 3'b000, 1'b0, 4'b1010, 1'b0, 1, acc1);
    for (int i = 0; i < 4; i++) begin
      chk("not_alu_select", 32'(alu_select), 32'd0);
      @(negedge clk);
    end
    issue(4'b1100, 4'b0011, 3'b001, 1'b0, 4'b1111, 1'b0, 1, acc1);
    issue(4'b1010, 4'b0110, 3'b010, 1'b0, 4'b1100, 1'b0, 1, acc1);

    // carry threading
    issue(4'hF, 4'h1, 3'b100, 1'b0, 4'h0, 1'b1, 1, acc1);
    issue(4'h7, 4'h8, 3'b100, 1'b1, 4'h0, 1'b1, 1, acc1);
    issue(4'h5, 4'h6, 3'b100, 1'b0, 4'hB, 1'b0, 1, acc1);
    drain();

    // back-to-back with rsp_ready held high
    issue(4'h9, 4'h9, 3'b100, 1'b0, 4'h2, 1'b1, 1, acc1);
    issue(4'hF, 4'h5, 3'b010, 1'b0, 4'hA, 1'b0, 1, acc2);
    drain();
    chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd6);
    chk("b2b_total_cycles", 32'(last_hs - acc1 + 1), 32'd12);

    // backpressure, with the next request pending while DONE
    rsp_ready = 1'b0;
    issue(4'h3, 4'h4, 3'b100, 1'b0, 4'h7, 1'b0, 1, acc1);
    fork
      issue(4'b0110, 4'b0011, 3'b011, 1'b0, 4'b0010, 1'b0, 1, acc2);
      begin
        int guard = 0;
        while (!rsp_valid && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        t_hs = cyc + 1;
      end
    join
    chk("bp_accept_after_release", 32'(acc2), 32'(t_hs + 1));
    drain();

    // reset mid-RUN: accepted op is aborted
    issue(4'hF, 4'hF, 3'b100, 1'b0, 4'h0, 1'b0, 0, acc1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_ready", 32'(req_ready), 32'd0);
    chk("midrun_rst_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_result", 32'(rsp_result), 32'd0);
    issue(4'h3, 4'h5, 3'b011, 1'b0, 4'h1, 1'b0, 1, acc1);
    drain();

    // WIDTH=8
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    issue8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    drain();

    chk("queue_empty", 32'(q.size() + q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial driver for the 1-bit `alu1` slice. It accepts a WIDTH-bit operation request over a valid/ready handshake and feeds the operand bits to one `alu1` instance, LSB first, one bit per clock. It threads the slice's carry_out back into carry_in and assembles the WIDTH-bit result, which it returns over a valid/ready response handshake. It sits between the requester (register file or test controller) and the `alu1` slice, and is the initiator side of the slice's a/b/carry_in/select → out/carry_out interface.

## Interface
- WIDTH, 4, operand/result width in bits; WIDTH ≥ 2; bit counter is $clog2(WIDTH) bits.

Clock and reset:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low: one clock, reset is synchronous and active-low.

Request and response:
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_select  in  3  slice select; passed unchanged to the slice. [2] chooses arith/logic; [1:0] chooses the operation.
- req_carry_in  in  1  carry seed for bit 0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  requester takes the result.
- rsp_result  out  WIDTH  assembled result.
- rsp_carry_out  out  1  carry from the MSB slice cycle.

Slice side:
- alu_a  out  1  operand A bit to the slice.
- alu_b  out  1  operand B bit to the slice.
- alu_carry_in  out  1  carry to the slice.
- alu_select  out  3  select to the slice.
- alu_out  in  1  slice result bit.
- alu_carry_out  in  1  slice carry.

## Operation
State machine with three states: IDLE, RUN, DONE.

- IDLE
  - req_ready=1.
  - On req_valid at an edge:
    - a_sh←req_a, b_sh←req_b, sel_r←req_select, carry_r←req_carry_in.
    - idx←0, res_sh←0.
    - Go to RUN.
- RUN
  - Combinational drive: alu_a=a_sh[0], alu_b=b_sh[0], alu_carry_in=carry_r, alu_select=sel_r.
  - Each edge:
    - res_sh←{alu_out, res_sh[WIDTH-1:1]}.
    - carry_r←alu_carry_out.
    - a_sh and b_sh shift right by one.
    - idx←idx+1.
  - On the edge where idx==WIDTH-1, go to DONE.
- DONE
  - rsp_valid=1, rsp_result=res_sh, rsp_carry_out=carry_r.
  - On rsp_ready at an edge, go to IDLE.
  - Result and carry are held stable while rsp_ready=0.
- Outside RUN: alu_a, alu_b and alu_carry_in are driven 0; alu_select=sel_r.
- The sequencer does not decode select. Carry is always threaded, including for logic ops; rsp_carry_out then carries whatever the slice reports.
- No bypass. req_ready=0 during RUN and DONE, so a request presented then waits.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE and all registers clear.
  - After that edge: req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry_out=0, alu_*=0.
  - While rst_n=0, req_ready is forced 0 and requests are ignored.
- Reset mid-RUN or in DONE: the operation is aborted, no response is produced, and the sequencer returns to IDLE.
- Latency. Acceptance edge E0; slice bit i is evaluated in the cycle before edge E(i+1). rsp_valid rises after edge E_WIDTH, i.e. WIDTH edges after acceptance.
- The DONE→IDLE edge and the next acceptance edge are distinct. Minimum period is WIDTH+2 cycles per operation.
- rsp_ready may be held high in advance. The response then lasts exactly one cycle.
- Simultaneous req_valid and rsp_ready in DONE: only the response completes; the request is accepted in the following IDLE cycle.
- The slice is combinational. alu_out and alu_carry_out are sampled in the same cycle the bits are driven.

## Test plan
- Logic AND, real `alu1` on the slice port: select=3'b011, a=4'b1100, b=4'b1010 → rsp_result=4'b1000, rsp_valid after exactly 4 edges.
- Logic NOT: select=3'b000, a=4'b0101 → rsp_result=4'b1010. Also check that alu_select=3'b000 throughout RUN.
- Carry threading, using a full-adder stub on the slice port: a=4'hF, b=4'h1, cin=0 → result 4'h0, carry 1. Then a=4'h7, b=4'h8, cin=1 → 4'h0, carry 1.
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - rsp_result and rsp_carry_out stay stable and req_ready stays 0.
  - On rsp_ready=1 the next request is accepted one cycle later.
  - Total cycles for two back-to-back ops with no stall = 12 at WIDTH=4.
- Reset mid-RUN: drop rst_n at the 2nd RUN edge, release, then issue a=4'h3, b=4'h5 AND → no stale rsp_valid, result 4'h1.
- WIDTH=8 parameterisation with the full-adder stub: a=8'hFF, b=8'h01 → 8'h00, carry 1, rsp_valid after 8 edges.
